// File: rtl/breathe_pwm_engine.sv
// breathe_pwm_engine: shared triangular brightness ramp ("breathe") converted to
// PWM and gated onto three LED channels. Flags each dark point at the end of a
// full breathe cycle so the upstream colour sequencer can switch colours safely.
module breathe_pwm_engine #(
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned PERIOD_W       = 32,
    parameter bit          OUT_ACTIVE_LOW = 1'b0
) (
    input  logic                Sys_Clk0,
    input  logic                Sys_Clk0_Rst,
    input  logic [PERIOD_W-1:0] period,
    input  logic [2:0]          enable,
    output logic [2:0]          led_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic                cycle_end_o
);

    typedef enum logic {
        ST_INHALE = 1'b0,
        ST_EXHALE = 1'b1
    } state_t;

    localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] LVL_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] PER_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] PER_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]          LED_RST  = OUT_ACTIVE_LOW ? 3'b111 : 3'b000;

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [PERIOD_W-1:0] step_cnt_q;
    logic [PERIOD_W-1:0] step_cnt_d;
    logic [PERIOD_W-1:0] period_m1_s;
    logic                tick_s;
    logic                idle_s;
    state_t              state_q;
    logic [PWM_BITS-1:0] level_q;
    logic                cycle_end_q;
    logic [2:0]          led_on_s;
    logic [2:0]          led_d;
    logic [2:0]          led_q;

    // Step timing: a period of 0 behaves like 1; the >= compare makes a
    // shrinking period end the current step on the very next clock.
    always_comb begin
        period_m1_s = PER_ZERO;
        if (period == PER_ZERO) begin
            period_m1_s = PER_ZERO;
        end else begin
            period_m1_s = period - PER_ONE;
        end
        idle_s = (enable == 3'b000);
        tick_s = (step_cnt_q >= period_m1_s);
    end

    // Next-state for the free-running PWM counter and the step counter.
    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + LVL_ONE;
        step_cnt_d = step_cnt_q + PER_ONE;
        if (idle_s) begin
            step_cnt_d = PER_ZERO;
        end else if (tick_s) begin
            step_cnt_d = PER_ZERO;
        end else begin
            step_cnt_d = step_cnt_q + PER_ONE;
        end
    end

    // Per-channel PWM compare, polarity applied before the output register.
    always_comb begin
        led_on_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (enable[i] && (level_q > pwm_cnt_q)) begin
                led_on_s[i] = 1'b1;
            end else begin
                led_on_s[i] = 1'b0;
            end
        end
        if (OUT_ACTIVE_LOW) begin
            led_d = ~led_on_s;
        end else begin
            led_d = led_on_s;
        end
    end

    // Counter registers.
    always_ff @(posedge Sys_Clk0 or posedge Sys_Clk0_Rst) begin
        if (Sys_Clk0_Rst) begin
            pwm_cnt_q  <= LVL_ZERO;
            step_cnt_q <= PER_ZERO;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // Breathe FSM: ramps level up then down, clamping at the turnarounds,
    // and pulses cycle_end when the falling ramp leaves the dark point.
    always_ff @(posedge Sys_Clk0 or posedge Sys_Clk0_Rst) begin
        if (Sys_Clk0_Rst) begin
            state_q     <= ST_INHALE;
            level_q     <= LVL_ZERO;
            cycle_end_q <= 1'b0;
        end else if (idle_s) begin
            state_q     <= ST_INHALE;
            level_q     <= LVL_ZERO;
            cycle_end_q <= 1'b0;
        end else begin
            cycle_end_q <= 1'b0;
            if (tick_s) begin
                case (state_q)
                    ST_INHALE: begin
                        if (level_q == LVL_MAX) begin
                            state_q <= ST_EXHALE;
                        end else begin
                            level_q <= level_q + LVL_ONE;
                        end
                    end
                    ST_EXHALE: begin
                        if (level_q == LVL_ZERO) begin
                            state_q     <= ST_INHALE;
                            cycle_end_q <= 1'b1;
                        end else begin
                            level_q <= level_q - LVL_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_INHALE;
                        level_q <= LVL_ZERO;
                    end
                endcase
            end
        end
    end

    // LED output register.
    always_ff @(posedge Sys_Clk0 or posedge Sys_Clk0_Rst) begin
        if (Sys_Clk0_Rst) begin
            led_q <= LED_RST;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_o       = led_q;
    assign level_o     = level_q;
    assign cycle_end_o = cycle_end_q;

endmodule

// File: tb/tb_breathe_pwm_engine.sv
// Directed bench for breathe_pwm_engine with PWM_BITS = 3: an active-high and an
// active-low instance share all inputs; expected values come from closed-form
// ramp formulas (level held per step, 16 steps per breathe cycle).
module tb_breathe_pwm_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] period;
    logic [2:0]  enable;
    logic [2:0]  led;
    logic [2:0]  led_al;
    logic [2:0]  level;
    logic [2:0]  level_al;
    logic        ce;
    logic        ce_al;

    int tests    = 0;
    int fails    = 0;
    int tcnt     = 0;
    int last_lvl = 0;

    breathe_pwm_engine #(.PWM_BITS(3), .PERIOD_W(32), .OUT_ACTIVE_LOW(1'b0)) dut (
        .Sys_Clk0(clk), .Sys_Clk0_Rst(rst), .period(period), .enable(enable),
        .led_o(led), .level_o(level), .cycle_end_o(ce)
    );

    breathe_pwm_engine #(.PWM_BITS(3), .PERIOD_W(32), .OUT_ACTIVE_LOW(1'b1)) dut_al (
        .Sys_Clk0(clk), .Sys_Clk0_Rst(rst), .period(period), .enable(enable),
        .led_o(led_al), .level_o(level_al), .cycle_end_o(ce_al)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Triangular ramp, 8 up-levels then 8 down-levels, each held 'per' clocks.
    function automatic int exp_level(input int n, input int per);
        int m;
        m = (n / per) % 16;
        return (m < 8) ? m : 15 - m;
    endfunction

    function automatic bit exp_ce(input int n, input int per);
        return (n > 0) && ((n % (16 * per)) == 0);
    endfunction

    // One clock: LED expectation uses enable/level/pwm seen before the edge.
    task automatic cyc(input int lvl_exp, input bit ce_exp, input string tag);
        logic [2:0] en_now;
        logic [2:0] exp_led;
        int pwm_now;
        int lvl_now;
        en_now  = enable;
        pwm_now = tcnt % 8;
        lvl_now = last_lvl;
        @(posedge clk);
        #1;
        tcnt++;
        exp_led = (lvl_now > pwm_now) ? en_now : 3'b000;
        chk({tag, " level"}, {29'd0, level}, lvl_exp);
        chk({tag, " cycle_end"}, {31'd0, ce}, {31'd0, ce_exp});
        chk({tag, " led"}, {29'd0, led}, {29'd0, exp_led});
        chk({tag, " led_al"}, {29'd0, led_al}, {29'd0, ~exp_led});
        last_lvl = lvl_exp;
    endtask

    task automatic run(input int per, input int n_first, input int n_last, input string tag);
        for (int n = n_first; n <= n_last; n++) begin
            cyc(exp_level(n, per), exp_ce(n, per), tag);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " led"}, {29'd0, led}, 32'd0);
        chk({tag, " led_al"}, {29'd0, led_al}, 32'd7);
        chk({tag, " level"}, {29'd0, level}, 32'd0);
        chk({tag, " cycle_end"}, {31'd0, ce}, 32'd0);
    endtask

    initial begin
        // Reset with all channels enabled
        rst    = 1'b1;
        enable = 3'b111;
        period = 32'd4;
        #2;
        reset_checks("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_checks("rst_hold");

        // Full ramp, period 4, red only; two full cycles plus a bit
        rst      = 1'b0;
        enable   = 3'b001;
        tcnt     = 0;
        last_lvl = 0;
        run(4, 1, 130, "ramp");

        // Period 0 behaves as 1: 16-clock cycle
        enable = 3'b000;
        cyc(0, 1'b0, "idle_p0");
        enable = 3'b001;
        period = 32'd0;
        run(1, 1, 32, "per0");

        // Period 1: 16-clock cycle
        enable = 3'b000;
        cyc(0, 1'b0, "idle_p1");
        enable = 3'b001;
        period = 32'd1;
        run(1, 1, 32, "per1");

        // Shrinking period mid-step ends the step on the next clock
        enable = 3'b000;
        cyc(0, 1'b0, "idle_pc");
        enable = 3'b001;
        period = 32'd100;
        run(100, 1, 50, "per100");
        period = 32'd2;
        cyc(1, 1'b0, "shrink_tick");
        cyc(1, 1'b0, "shrink_hold");
        cyc(2, 1'b0, "shrink_next");

        // Idle restart from level 5 while exhaling
        enable = 3'b000;
        cyc(0, 1'b0, "idle_ir");
        enable = 3'b001;
        period = 32'd4;
        run(4, 1, 41, "to_exh5");
        chk("exh5 level", {29'd0, level}, 32'd5);
        enable = 3'b000;
        cyc(0, 1'b0, "idle1");
        cyc(0, 1'b0, "idle2");
        cyc(0, 1'b0, "idle3");
        enable = 3'b110;
        run(4, 1, 40, "restart");

        // Channel gating: green leaves the ramp without disturbing it
        enable = 3'b000;
        cyc(0, 1'b0, "idle_g");
        enable = 3'b111;
        run(4, 1, 20, "gate_all");
        enable = 3'b101;
        run(4, 21, 44, "gate_no_g");

        // Reset mid-ramp at level 6, then a full cycle from dark
        enable = 3'b000;
        cyc(0, 1'b0, "idle_r");
        enable = 3'b001;
        run(4, 1, 25, "to_lvl6");
        chk("lvl6 level", {29'd0, level}, 32'd6);
        #2;
        rst = 1'b1;
        #1;
        reset_checks("rst_mid");
        @(posedge clk);
        #1;
        reset_checks("rst_mid_hold");
        rst      = 1'b0;
        tcnt     = 0;
        last_lvl = 0;
        run(4, 1, 66, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
